byte_count_hls_deadlock_reporter: RTL and testbench

- Sits downstream of the byte_count dataflow deadlock monitor and consumes its per-cycle `block` flag.
- Confirms that a deadlock persists for a programmable number of cycles.
- On confirmation, snapshots the per-process idle/channel-block/AXIS-block status vectors plus a timestamp, and emits one report per deadlock episode over a valid/ready handshake to the debug/status path.
- Also keeps a sticky deadlock flag and a saturating report counter for software polling.

---
 rtl/byte_count_hls_deadlock_reporter.sv | 171 +++++++++++++++++
 tb/tb_byte_count_hls_deadlock_reporter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/byte_count_hls_deadlock_reporter.sv
// Confirms a persistent dataflow deadlock from the monitor's block flag and emits one
// snapshot report per episode over valid/ready, plus sticky flag and report counter.
module byte_count_hls_deadlock_reporter #(
    parameter int NUM_PROC       = 9,
    parameter int CONFIRM_CYCLES = 16,
    parameter int TS_WIDTH       = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                block,
    input  logic [NUM_PROC-1:0] proc_idle_sigs,
    input  logic [NUM_PROC-1:0] proc_chan_block_sigs,
    input  logic [NUM_PROC-1:0] proc_axis_block_sigs,
    input  logic                clear,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [NUM_PROC-1:0] rpt_idle,
    output logic [NUM_PROC-1:0] rpt_chan_block,
    output logic [NUM_PROC-1:0] rpt_axis_block,
    output logic [TS_WIDTH-1:0] rpt_timestamp,
    output logic [7:0]          rpt_count,
    output logic                deadlock_sticky
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        REPORT  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [15:0] CONFIRM_LIMIT = 16'(CONFIRM_CYCLES);

    state_t              state_r;
    state_t              state_next_s;
    logic [15:0]         confirm_cnt_r;
    logic [15:0]         confirm_cnt_next_s;
    logic [15:0]         confirm_inc_s;
    logic                capture_s;
    logic                handshake_s;
    logic                rpt_valid_r;
    logic [NUM_PROC-1:0] idle_r;
    logic [NUM_PROC-1:0] chan_block_r;
    logic [NUM_PROC-1:0] axis_block_r;
    logic [TS_WIDTH-1:0] timestamp_r;
    logic [TS_WIDTH-1:0] rpt_timestamp_r;
    logic [7:0]          rpt_count_r;
    logic                sticky_r;

    assign handshake_s   = rpt_valid_r & rpt_ready;
    assign confirm_inc_s = confirm_cnt_r + 16'd1;

    // Next-state, confirm counter and capture strobe
    always_comb begin
        state_next_s       = state_r;
        confirm_cnt_next_s = confirm_cnt_r;
        capture_s          = 1'b0;
        case (state_r)
            IDLE: begin
                if (block) begin
                    if (CONFIRM_LIMIT == 16'd1) begin
                        capture_s          = 1'b1;
                        confirm_cnt_next_s = 16'd0;
                        state_next_s       = REPORT;
                    end else begin
                        confirm_cnt_next_s = 16'd1;
                        state_next_s       = CONFIRM;
                    end
                end else begin
                    confirm_cnt_next_s = 16'd0;
                end
            end
            CONFIRM: begin
                if (!block) begin
                    confirm_cnt_next_s = 16'd0;
                    state_next_s       = IDLE;
                end else if (confirm_inc_s == CONFIRM_LIMIT) begin
                    capture_s          = 1'b1;
                    confirm_cnt_next_s = 16'd0;
                    state_next_s       = REPORT;
                end else begin
                    confirm_cnt_next_s = confirm_inc_s;
                end
            end
            REPORT: begin
                if (handshake_s) begin
                    state_next_s = block ? HOLD : IDLE;
                end else begin
                    state_next_s = REPORT;
                end
            end
            HOLD: begin
                if (!block) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s       = IDLE;
                confirm_cnt_next_s = 16'd0;
            end
        endcase
    end

    // FSM, counter and registered valid; valid is derived from the next state so it never
    // depends combinationally on rpt_ready
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            confirm_cnt_r <= 16'd0;
            rpt_valid_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            confirm_cnt_r <= confirm_cnt_next_s;
            rpt_valid_r   <= (state_next_s == REPORT);
        end
    end

    // Free-running timestamp, wraps silently
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timestamp_r <= '0;
        end else begin
            timestamp_r <= timestamp_r + {{(TS_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Payload snapshot, held until the next capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_r          <= '0;
            chan_block_r    <= '0;
            axis_block_r    <= '0;
            rpt_timestamp_r <= '0;
        end else if (capture_s) begin
            idle_r          <= proc_idle_sigs;
            chan_block_r    <= proc_chan_block_sigs;
            axis_block_r    <= proc_axis_block_sigs;
            rpt_timestamp_r <= timestamp_r;
        end
    end

    // Software-visible status; clear beats a handshake, capture beats clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_count_r <= 8'd0;
            sticky_r    <= 1'b0;
        end else begin
            if (clear) begin
                rpt_count_r <= 8'd0;
            end else if (handshake_s && (rpt_count_r != 8'hFF)) begin
                rpt_count_r <= rpt_count_r + 8'd1;
            end
            if (capture_s) begin
                sticky_r <= 1'b1;
            end else if (clear) begin
                sticky_r <= 1'b0;
            end
        end
    end

    assign rpt_valid       = rpt_valid_r;
    assign rpt_idle        = idle_r;
    assign rpt_chan_block  = chan_block_r;
    assign rpt_axis_block  = axis_block_r;
    assign rpt_timestamp   = rpt_timestamp_r;
    assign rpt_count       = rpt_count_r;
    assign deadlock_sticky = sticky_r;

endmodule

// File: tb/tb_byte_count_hls_deadlock_reporter.sv
// Directed bench: glitch rejection, capture, backpressure, episodes, saturation, clear, reset.
module tb_byte_count_hls_deadlock_reporter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        block = 1'b0;
    logic        block_b = 1'b0;
    logic [8:0]  idle_v = 9'h000;
    logic [8:0]  chan_v = 9'h000;
    logic [8:0]  axis_v = 9'h000;
    logic        clear = 1'b0;
    logic        rpt_ready = 1'b0;
    logic        rpt_ready_b = 1'b0;

    logic        rpt_valid, rpt_valid_b;
    logic [8:0]  rpt_idle, rpt_chan_block, rpt_axis_block;
    logic [8:0]  rpt_idle_b, rpt_chan_block_b, rpt_axis_block_b;
    logic [31:0] rpt_timestamp, rpt_timestamp_b;
    logic [7:0]  rpt_count, rpt_count_b;
    logic        deadlock_sticky, deadlock_sticky_b;

    int          checks = 0;
    int          errors = 0;
    logic        seen_valid;
    logic [31:0] ts_m;

    byte_count_hls_deadlock_reporter #(.NUM_PROC(9), .CONFIRM_CYCLES(16), .TS_WIDTH(32)) dut_a (
        .clock(clock), .reset(reset), .block(block),
        .proc_idle_sigs(idle_v), .proc_chan_block_sigs(chan_v), .proc_axis_block_sigs(axis_v),
        .clear(clear), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_idle(rpt_idle), .rpt_chan_block(rpt_chan_block), .rpt_axis_block(rpt_axis_block),
        .rpt_timestamp(rpt_timestamp), .rpt_count(rpt_count), .deadlock_sticky(deadlock_sticky)
    );

    byte_count_hls_deadlock_reporter #(.NUM_PROC(9), .CONFIRM_CYCLES(1), .TS_WIDTH(32)) dut_b (
        .clock(clock), .reset(reset), .block(block_b),
        .proc_idle_sigs(idle_v), .proc_chan_block_sigs(chan_v), .proc_axis_block_sigs(axis_v),
        .clear(clear), .rpt_valid(rpt_valid_b), .rpt_ready(rpt_ready_b),
        .rpt_idle(rpt_idle_b), .rpt_chan_block(rpt_chan_block_b), .rpt_axis_block(rpt_axis_block_b),
        .rpt_timestamp(rpt_timestamp_b), .rpt_count(rpt_count_b), .deadlock_sticky(deadlock_sticky_b)
    );

    always #5 clock = ~clock;

    // Reference timestamp: value the DUT counter holds between edges
    always @(posedge clock or posedge reset) begin
        if (reset) ts_m <= 32'd0;
        else       ts_m <= ts_m + 32'd1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rpt_valid) seen_valid = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !rpt_valid; i++) tick();
        check(tag, {31'd0, rpt_valid}, 32'd1);
    endtask

    // One fast episode with ready already high: valid, handshake, then block released
    task automatic episode();
        block = 1'b1;
        rpt_ready = 1'b1;
        wait_valid("sat_valid");
        tick();
        block = 1'b0;
        rpt_ready = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_valid",  {31'd0, rpt_valid}, 32'd0);
        check("rst_count",  {24'd0, rpt_count}, 32'd0);
        check("rst_sticky", {31'd0, deadlock_sticky}, 32'd0);
        check("rst_ts",     rpt_timestamp, 32'd0);
        check("rst_idle",   {23'd0, rpt_idle}, 32'd0);
        check("rst_state",  32'(dut_a.state_r), 32'd0);
        #6 reset = 1'b0;

        // Glitch: 15 high cycles must not confirm
        for (int i = 0; i < 20; i++) tick();
        seen_valid = 1'b0;
        block = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        block = 1'b0;
        tick();
        tick();
        check("glitch_valid",  {31'd0, seen_valid}, 32'd0);
        check("glitch_sticky", {31'd0, deadlock_sticky}, 32'd0);
        check("glitch_state",  32'(dut_a.state_r), 32'd0);

        // Confirmed capture with block rising while timestamp is 100
        for (int i = 0; i < 200 && ts_m != 32'd100; i++) tick();
        check("ts_align", ts_m, 32'd100);
        idle_v = 9'h0F0;
        chan_v = 9'h00E;
        axis_v = 9'h001;
        block  = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("cap_early",  {31'd0, rpt_valid}, 32'd0);
        tick();
        check("cap_valid",  {31'd0, rpt_valid}, 32'd1);
        check("cap_ts",     rpt_timestamp, 32'd115);
        check("cap_idle",   {23'd0, rpt_idle}, 32'h0F0);
        check("cap_chan",   {23'd0, rpt_chan_block}, 32'h00E);
        check("cap_axis",   {23'd0, rpt_axis_block}, 32'h001);
        check("cap_sticky", {31'd0, deadlock_sticky}, 32'd1);
        check("cap_count",  {24'd0, rpt_count}, 32'd0);

        // Backpressure with toggling vectors
        for (int i = 0; i < 20; i++) begin
            idle_v = 9'($urandom);
            chan_v = 9'($urandom);
            axis_v = 9'($urandom);
            tick();
        end
        check("bp_valid", {31'd0, rpt_valid}, 32'd1);
        check("bp_idle",  {23'd0, rpt_idle}, 32'h0F0);
        check("bp_chan",  {23'd0, rpt_chan_block}, 32'h00E);
        check("bp_axis",  {23'd0, rpt_axis_block}, 32'h001);
        check("bp_ts",    rpt_timestamp, 32'd115);
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        check("hs_valid", {31'd0, rpt_valid}, 32'd0);
        check("hs_count", {24'd0, rpt_count}, 32'd1);
        check("hs_state", 32'(dut_a.state_r), 32'd3);

        // One report per episode
        seen_valid = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        check("hold_novalid", {31'd0, seen_valid}, 32'd0);
        block = 1'b0;
        tick();
        block = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("ep2_early", {31'd0, rpt_valid}, 32'd0);
        tick();
        check("ep2_valid", {31'd0, rpt_valid}, 32'd1);
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        block = 1'b0;
        tick();
        check("ep2_count", {24'd0, rpt_count}, 32'd2);
        check("ep2_state", 32'(dut_a.state_r), 32'd0);

        // Saturation at 255
        for (int i = 0; i < 253; i++) episode();
        check("sat_255", {24'd0, rpt_count}, 32'd255);
        episode();
        check("sat_hold", {24'd0, rpt_count}, 32'd255);

        // Clear coincident with handshake
        block = 1'b1;
        wait_valid("clr_wait");
        rpt_ready = 1'b1;
        clear = 1'b1;
        tick();
        rpt_ready = 1'b0;
        clear = 1'b0;
        check("clr_count",  {24'd0, rpt_count}, 32'd0);
        check("clr_valid",  {31'd0, rpt_valid}, 32'd0);
        check("clr_sticky", {31'd0, deadlock_sticky}, 32'd0);
        block = 1'b0;
        tick();

        // Clear coincident with capture
        block = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("cc_pre_sticky", {31'd0, deadlock_sticky}, 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("cc_valid",  {31'd0, rpt_valid}, 32'd1);
        check("cc_sticky", {31'd0, deadlock_sticky}, 32'd1);

        // Asynchronous reset mid-report
        #2 reset = 1'b1;
        #1;
        check("ar_valid",  {31'd0, rpt_valid}, 32'd0);
        check("ar_sticky", {31'd0, deadlock_sticky}, 32'd0);
        check("ar_idle",   {23'd0, rpt_idle}, 32'd0);
        check("ar_ts",     rpt_timestamp, 32'd0);
        check("ar_state",  32'(dut_a.state_r), 32'd0);
        block = 1'b0;
        #3 reset = 1'b0;
        tick();
        tick();

        // Single-cycle confirmation instance
        check("n1_pre", {31'd0, rpt_valid_b}, 32'd0);
        block_b = 1'b1;
        tick();
        block_b = 1'b0;
        check("n1_valid",  {31'd0, rpt_valid_b}, 32'd1);
        check("n1_sticky", {31'd0, deadlock_sticky_b}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
